// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and constants for the fetch sequencer.
package fetch_pkg;
    typedef enum logic [2:0] {BOOT, IDLE, REQ, DONE, PREF} fetch_state_t;
    localparam int INST_BYTES = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/fetch_prebuf.sv
// fetch_prebuf: one-entry prefetch buffer with valid bit and address match.
module fetch_prebuf #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_i,
    input  logic              flush_i,
    input  logic              consume_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [ADDR_W-1:0] look_addr_i,
    output logic              hit_o,
    output logic [DATA_W-1:0] data_o
);
    logic              valid_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else if (flush_i || consume_i) begin
            valid_q <= 1'b0;
        end else if (wr_i) begin
            valid_q <= 1'b1;
            addr_q  <= wr_addr_i;
            data_q  <= wr_data_i;
        end
    end

    assign hit_o  = valid_q && addr_q == look_addr_i;
    assign data_o = data_q;
endmodule

// File: rtl/fetch_seq.sv
// fetch_seq: instruction-fetch sequencer between the phase controller and the imem req/ack port.
// FETCH_PREBUF_EN adds a one-entry sequential prefetch buffer (fetch_prebuf).
module fetch_seq
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
    parameter int                TIMEOUT  = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fe_start,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              imem_err,
    output logic              inst_ready,
    output logic [DATA_W-1:0] inst,
    output logic [ADDR_W-1:0] pc,
    output logic              fetch_fault
);
    localparam logic [3:0]        TO   = 4'(TIMEOUT);
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(INST_BYTES);

    fetch_state_t      state_q;
    logic              req_q, rdy_q, fault_q, start, br, tmo, hit;
    logic [ADDR_W-1:0] addr_q, pc_q, tgt, nxt;
    logic [DATA_W-1:0] inst_q, buf_data;
    logic [3:0]        cnt_q, cnt_d;

    assign cnt_d = cnt_q + 4'd1;
    assign tmo   = !imem_ack && cnt_d == TO;
    assign nxt   = br ? tgt : pc_q + STEP;

`ifdef FETCH_PREBUF_EN
    // A start seen during PREF is held here and replayed from IDLE once the prefetch settles.
    logic              pend_q, pend_br_q;
    logic [ADDR_W-1:0] pend_tgt_q;

    assign start = state_q == IDLE && (fe_start || pend_q);
    assign br    = pend_q ? pend_br_q : br_taken;
    assign tgt   = pend_q ? pend_tgt_q : br_target;

    fetch_prebuf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_prebuf (
        .clk         (clk),
        .rst         (rst),
        .wr_i        (state_q == PREF && imem_ack && !imem_err && !pend_q),
        .flush_i     ((state_q == PREF && imem_ack && imem_err) || (start && br)),
        .consume_i   (start && !br && hit),
        .wr_addr_i   (addr_q),
        .wr_data_i   (imem_rdata),
        .look_addr_i (nxt),
        .hit_o       (hit),
        .data_o      (buf_data)
    );
`else
    assign start    = state_q == IDLE && fe_start;
    assign br       = br_taken;
    assign tgt      = br_target;
    assign hit      = 1'b0;
    assign buf_data = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BOOT;
            req_q   <= 1'b0;
            addr_q  <= RESET_PC;
            rdy_q   <= 1'b0;
            inst_q  <= '0;
            pc_q    <= RESET_PC;
            fault_q <= 1'b0;
            cnt_q   <= '0;
`ifdef FETCH_PREBUF_EN
            pend_q     <= 1'b0;
            pend_br_q  <= 1'b0;
            pend_tgt_q <= '0;
`endif
        end else begin
            rdy_q <= 1'b0;
            case (state_q)
                BOOT: begin
                    req_q   <= 1'b1;
                    cnt_q   <= '0;
                    state_q <= REQ;
                end
                IDLE: if (start) begin
`ifdef FETCH_PREBUF_EN
                    pend_q <= 1'b0;
`endif
                    fault_q <= |nxt[1:0];
                    if (nxt[1:0] == 2'b00 && !br && hit) begin
                        inst_q  <= buf_data;
                        pc_q    <= nxt;
                        rdy_q   <= 1'b1;
                        state_q <= DONE;
                    end else if (nxt[1:0] == 2'b00) begin
                        addr_q  <= nxt;
                        req_q   <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (imem_ack || tmo) begin
                        req_q   <= 1'b0;
                        fault_q <= tmo || imem_err;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                    if (imem_ack && !imem_err) begin
                        inst_q  <= imem_rdata;
                        pc_q    <= addr_q;
                        rdy_q   <= 1'b1;
                        state_q <= DONE;
                    end
                end
`ifdef FETCH_PREBUF_EN
                DONE: begin
                    addr_q  <= pc_q + STEP;
                    req_q   <= 1'b1;
                    cnt_q   <= '0;
                    state_q <= PREF;
                end
                PREF: begin
                    if (fe_start && !pend_q) begin
                        pend_q     <= 1'b1;
                        pend_br_q  <= br_taken;
                        pend_tgt_q <= br_target;
                    end
                    if (imem_ack || tmo) begin
                        req_q   <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                    if (pend_q && !pend_br_q && imem_ack && !imem_err) begin
                        inst_q  <= imem_rdata;
                        pc_q    <= addr_q;
                        rdy_q   <= 1'b1;
                        pend_q  <= 1'b0;
                        fault_q <= 1'b0;
                        state_q <= DONE;
                    end
                end
`else
                DONE: state_q <= IDLE;
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign inst_ready  = rdy_q;
    assign inst        = inst_q;
    assign pc          = pc_q;
    assign fetch_fault = fault_q;
endmodule
